// File: rtl/conv_pkg.sv
// Shared definitions for the convolution engine and its result receiver:
// receiver state encoding, default buffer geometry and the output-size helper.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_COMPLETE,
    ST_ERROR
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 64;

  // Number of output words for an N x N input, M x M kernel and stride S.
  // Returns 0 for configurations that cannot produce an output.
  function automatic logic [12:0] out_count(input logic [5:0] n,
                                            input logic [5:0] m,
                                            input logic [5:0] s);
    logic [5:0] p;
    if (s == 6'd0 || m == 6'd0 || m > n) return 13'd0;
    p = (n - m) / s + 6'd1;
    return 13'(p) * 13'(p);
  endfunction

endpackage

// File: rtl/conv_rx_mem.sv
// Result buffer: simple dual-port RAM with one write port and a registered
// read port; a same-address read and write in one cycle returns the old word.
module conv_rx_mem #(
  parameter int Width = 16,
  parameter int Depth = 64,
  parameter int AW    = 6
) (
  input  logic             CLK,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [Width-1:0] rd_data
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/conv_result_rx.sv
// Receive end of the convolution output stream: captures words into a buffer,
// counts them against the expected output size and serves host reads.
module conv_result_rx
  import conv_pkg::*;
#(
  parameter int Width = DEF_WIDTH,
  parameter int Depth = DEF_DEPTH,
  parameter int AW    = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [5:0]       N1,
  input  logic [5:0]       M1,
  input  logic [5:0]       S1,
  input  logic [Width-1:0] DATA_IN,
  input  logic             VALID_IN,
  input  logic             RD_EN,
  input  logic [AW-1:0]    RD_ADDR,
  output logic [Width-1:0] RD_DATA,
  output logic             RD_VALID,
  output logic [AW:0]      COUNT,
  output logic             BUSY,
  output logic             CAP_DONE,
  output logic             ERR_OVF,
  output logic             ERR_CFG
);

  localparam logic [AW:0] ONE = 1;

  state_t           state, state_nxt;
  logic [AW:0]      count, exp_q;
  logic [12:0]      exp_in;
  logic             cfg_ok, wr_en, last_word, err_ovf;
  logic             rd_ok_p1, rd_vld_p1;
  logic [Width-1:0] mem_rd_p1;

  assign exp_in    = out_count(N1, M1, S1);
  assign cfg_ok    = (S1 != 6'd0) && (M1 != 6'd0) && (M1 <= N1) &&
                     (exp_in <= 13'(Depth));
  // START takes priority: a word arriving with it is dropped.
  assign wr_en     = !START && VALID_IN &&
                     (state == ST_ARMED || state == ST_CAPTURE);
  assign last_word = (count + ONE) == exp_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (START) begin
      state_nxt = cfg_ok ? ST_ARMED : ST_ERROR;
    end else if (wr_en) begin
      state_nxt = last_word ? ST_COMPLETE : ST_CAPTURE;
    end
  end

  always_comb begin
    BUSY     = (state == ST_ARMED) || (state == ST_CAPTURE);
    CAP_DONE = (state == ST_COMPLETE);
    ERR_CFG  = (state == ST_ERROR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count   <= '0;
      exp_q   <= '0;
      err_ovf <= 1'b0;
    end else if (START) begin
      count   <= '0;
      exp_q   <= exp_in[AW:0];
      err_ovf <= 1'b0;
    end else begin
      if (wr_en) count <= count + ONE;
      if (VALID_IN && state == ST_COMPLETE) err_ovf <= 1'b1;
    end
  end

  // Read stage p0 -> p1: RAM output plus the address-in-range mask.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_vld_p1 <= 1'b0;
      rd_ok_p1  <= 1'b0;
    end else begin
      rd_vld_p1 <= RD_EN;
      if (RD_EN) rd_ok_p1 <= ({1'b0, RD_ADDR} < count);
    end
  end

  conv_rx_mem #(
    .Width (Width),
    .Depth (Depth),
    .AW    (AW)
  ) u_mem (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (count[AW-1:0]),
    .wr_data (DATA_IN),
    .rd_en   (RD_EN),
    .rd_addr (RD_ADDR),
    .rd_data (mem_rd_p1)
  );

  assign RD_DATA  = rd_ok_p1 ? mem_rd_p1 : '0;
  assign RD_VALID = rd_vld_p1;
  assign COUNT    = count;
  assign ERR_OVF  = err_ovf;

endmodule

// File: tb/tb_conv_result_rx.sv
// Self-checking bench for conv_result_rx: directed scenarios plus randomized
// sessions checked against a queue/array model of the receive rules.
module tb_conv_result_rx;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [5:0]  N1, M1, S1;
  logic [15:0] DATA_IN;
  logic        VALID_IN;
  logic        RD_EN;
  logic [5:0]  RD_ADDR;
  logic [15:0] RD_DATA;
  logic        RD_VALID;
  logic [6:0]  COUNT;
  logic        BUSY, CAP_DONE, ERR_OVF, ERR_CFG;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_mem [64];
  int          m_count, m_exp;
  bit          m_busy, m_done, m_err, m_ovf, m_rdv;
  logic [15:0] m_rd;

  conv_result_rx dut (
    .CLK(CLK), .RST(RST), .START(START), .N1(N1), .M1(M1), .S1(S1),
    .DATA_IN(DATA_IN), .VALID_IN(VALID_IN), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .COUNT(COUNT), .BUSY(BUSY),
    .CAP_DONE(CAP_DONE), .ERR_OVF(ERR_OVF), .ERR_CFG(ERR_CFG)
  );

  always #5 CLK = ~CLK;

  // Expected output size, or -1 when the configuration must be rejected.
  function automatic int ref_exp(input int n, input int m, input int s);
    int p;
    if (s == 0 || m == 0 || m > n) return -1;
    p = (n - m) / s + 1;
    if (p * p > 64) return -1;
    return p * p;
  endfunction

  task automatic model_reset();
    m_count = 0; m_exp = 0; m_busy = 0; m_done = 0; m_err = 0;
    m_ovf = 0; m_rdv = 0; m_rd = '0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample at +1.
  task automatic step(input bit st, input int n, input int m, input int s,
                      input bit v, input logic [15:0] d, input bit re, input int ra);
    int e;
    START = st; N1 = n[5:0]; M1 = m[5:0]; S1 = s[5:0];
    VALID_IN = v; DATA_IN = d; RD_EN = re; RD_ADDR = ra[5:0];
    @(posedge CLK);
    if (re) begin
      m_rdv = 1;
      m_rd  = (ra < m_count) ? m_mem[ra] : 16'h0;
    end else begin
      m_rdv = 0;
    end
    if (st) begin
      e = ref_exp(n, m, s);
      m_count = 0; m_ovf = 0; m_done = 0;
      m_err = (e < 0); m_busy = !m_err; m_exp = e;
    end else if (v) begin
      if (m_busy) begin
        m_mem[m_count] = d;
        m_count++;
        if (m_count == m_exp) begin m_busy = 0; m_done = 1; end
      end else if (m_done) begin
        m_ovf = 1;
      end
    end
    #1;
    START = 0; VALID_IN = 0; RD_EN = 0;
  endtask

  task automatic test_reset();
    RST = 1; START = 0; VALID_IN = 0; RD_EN = 0;
    N1 = 0; M1 = 0; S1 = 0; DATA_IN = 0; RD_ADDR = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if ({RD_DATA, RD_VALID, COUNT, BUSY, CAP_DONE, ERR_OVF, ERR_CFG} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got data=%h vld=%b cnt=%0d busy=%b done=%b ovf=%b cfg=%b want all 0",
               RD_DATA, RD_VALID, COUNT, BUSY, CAP_DONE, ERR_OVF, ERR_CFG);
    end
    @(negedge CLK);
    RST = 0;
  endtask

  task automatic test_basic();
    step(1, 4, 2, 1, 0, 0, 0, 0);
    n_cmp++;
    if (BUSY !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", BUSY); end
    for (int i = 1; i <= 9; i++) step(0, 0, 0, 0, 1, 16'(i), 0, 0);
    n_cmp++;
    if ({CAP_DONE, BUSY} !== 2'b10) begin
      n_bad++; $display("FAIL basic_done: got done=%b busy=%b want done=1 busy=0", CAP_DONE, BUSY);
    end
    n_cmp++;
    if (COUNT !== 7'd9) begin n_bad++; $display("FAIL basic_count: got %0d want 9", COUNT); end
    for (int a = 0; a <= 9; a++) begin
      step(0, 0, 0, 0, 0, 0, 1, a);
      n_cmp++;
      if (RD_VALID !== 1'b1 || RD_DATA !== ((a < 9) ? 16'(a + 1) : 16'h0)) begin
        n_bad++;
        $display("FAIL basic_read[%0d]: got vld=%b data=%h want vld=1 data=%h",
                 a, RD_VALID, RD_DATA, (a < 9) ? 16'(a + 1) : 16'h0);
      end
    end
    step(0, 0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (RD_VALID !== 1'b0 || RD_DATA !== 16'd4) begin
      n_bad++; $display("FAIL basic_hold: got vld=%b data=%h want vld=0 data=0004", RD_VALID, RD_DATA);
    end
  endtask

  task automatic test_gaps();
    step(1, 5, 3, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 16'hA0, 0, 0);
    step(0, 0, 0, 0, 1, 16'hA1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (BUSY !== 1'b1 || COUNT !== 7'd2) begin
        n_bad++; $display("FAIL gaps_idle: got busy=%b cnt=%0d want busy=1 cnt=2", BUSY, COUNT);
      end
    end
    step(0, 0, 0, 0, 1, 16'hA2, 0, 0);
    step(0, 0, 0, 0, 1, 16'hA3, 0, 0);
    n_cmp++;
    if (COUNT !== 7'd4 || CAP_DONE !== 1'b1 || ERR_OVF !== 1'b0) begin
      n_bad++; $display("FAIL gaps_end: got cnt=%0d done=%b ovf=%b want 4/1/0", COUNT, CAP_DONE, ERR_OVF);
    end
    for (int a = 0; a < 4; a++) begin
      step(0, 0, 0, 0, 0, 0, 1, a);
      n_cmp++;
      if (RD_DATA !== 16'(16'hA0 + a)) begin
        n_bad++; $display("FAIL gaps_read[%0d]: got %h want %h", a, RD_DATA, 16'(16'hA0 + a));
      end
    end
  endtask

  task automatic test_overflow();
    step(1, 3, 2, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 16'($urandom), 0, 0);
    n_cmp++;
    if (ERR_OVF !== 1'b1 || COUNT !== 7'd4 || CAP_DONE !== 1'b1) begin
      n_bad++; $display("FAIL ovf_flag: got ovf=%b cnt=%0d done=%b want 1/4/1", ERR_OVF, COUNT, CAP_DONE);
    end
    for (int a = 0; a <= 4; a++) begin
      step(0, 0, 0, 0, 0, 0, 1, a);
      n_cmp++;
      if (RD_DATA !== m_rd || (a == 4 && RD_DATA !== 16'h0)) begin
        n_bad++; $display("FAIL ovf_read[%0d]: got %h want %h", a, RD_DATA, m_rd);
      end
    end
    step(1, 4, 2, 1, 0, 0, 0, 0);
    n_cmp++;
    if (ERR_OVF !== 1'b0 || COUNT !== 7'd0 || BUSY !== 1'b1) begin
      n_bad++; $display("FAIL ovf_restart: got ovf=%b cnt=%0d busy=%b want 0/0/1", ERR_OVF, COUNT, BUSY);
    end
  endtask

  task automatic test_cfg_err();
    int cfg [3][3] = '{'{4, 2, 0}, '{4, 5, 1}, '{63, 1, 1}};
    for (int k = 0; k < 3; k++) begin
      step(1, cfg[k][0], cfg[k][1], cfg[k][2], 0, 0, 0, 0);
      n_cmp++;
      if (ERR_CFG !== 1'b1 || BUSY !== 1'b0) begin
        n_bad++; $display("FAIL cfg_err[%0d]: got err=%b busy=%b want 1/0", k, ERR_CFG, BUSY);
      end
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 16'($urandom), 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      n_cmp++;
      if (COUNT !== 7'd0 || RD_DATA !== 16'h0 || ERR_CFG !== 1'b1) begin
        n_bad++; $display("FAIL cfg_nocap[%0d]: got cnt=%0d data=%h err=%b want 0/0000/1", k, COUNT, RD_DATA, ERR_CFG);
      end
    end
  endtask

  task automatic test_rst_mid();
    step(1, 4, 2, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 16'($urandom), 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    #2 RST = 1;
    #1;
    model_reset();
    n_cmp++;
    if ({RD_DATA, RD_VALID, COUNT, BUSY, CAP_DONE, ERR_OVF, ERR_CFG} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid: got data=%h vld=%b cnt=%0d busy=%b done=%b ovf=%b cfg=%b want all 0",
               RD_DATA, RD_VALID, COUNT, BUSY, CAP_DONE, ERR_OVF, ERR_CFG);
    end
    @(negedge CLK);
    RST = 0;
    step(1, 4, 2, 1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1, 16'($urandom), 0, 0);
    n_cmp++;
    if (CAP_DONE !== 1'b1 || COUNT !== 7'd9) begin
      n_bad++; $display("FAIL rst_restart: got done=%b cnt=%0d want 1/9", CAP_DONE, COUNT);
    end
    for (int a = 0; a < 9; a++) begin
      step(0, 0, 0, 0, 0, 0, 1, a);
      n_cmp++;
      if (RD_DATA !== m_rd) begin
        n_bad++; $display("FAIL rst_read[%0d]: got %h want %h", a, RD_DATA, m_rd);
      end
    end
  endtask

  task automatic test_collide();
    step(1, 4, 2, 2, 1, 16'hDEAD, 0, 0);
    n_cmp++;
    if (COUNT !== 7'd0 || BUSY !== 1'b1) begin
      n_bad++; $display("FAIL collide_start: got cnt=%0d busy=%b want 0/1", COUNT, BUSY);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 16'(16'h0100 + i), 0, 0);
    n_cmp++;
    if (CAP_DONE !== 1'b1 || COUNT !== 7'd4) begin
      n_bad++; $display("FAIL collide_done: got done=%b cnt=%0d want 1/4", CAP_DONE, COUNT);
    end
    for (int a = 0; a < 4; a++) begin
      step(0, 0, 0, 0, 0, 0, 1, a);
      n_cmp++;
      if (RD_DATA !== 16'(16'h0100 + a)) begin
        n_bad++; $display("FAIL collide_read[%0d]: got %h want %h", a, RD_DATA, 16'(16'h0100 + a));
      end
    end
  endtask

  task automatic test_random();
    int n, m, s;
    for (int sess = 0; sess < 20; sess++) begin
      if ($urandom_range(0, 9) == 0) begin
        n = $urandom_range(0, 63); m = $urandom_range(0, 63); s = $urandom_range(0, 3);
      end else begin
        n = $urandom_range(1, 12); m = $urandom_range(1, n); s = $urandom_range(1, 4);
      end
      step(1, n, m, s, $urandom_range(0, 1), 16'($urandom), $urandom_range(0, 1), $urandom_range(0, 63));
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 99) < 3)
          step(1, n, m, s, $urandom_range(0, 1), 16'($urandom), $urandom_range(0, 1), $urandom_range(0, 63));
        else
          step(0, 0, 0, 0, ($urandom_range(0, 9) < 7), 16'($urandom),
               $urandom_range(0, 1), $urandom_range(0, 20));
        n_cmp++;
        if (COUNT !== 7'(m_count) || BUSY !== m_busy || CAP_DONE !== m_done ||
            ERR_OVF !== m_ovf || ERR_CFG !== m_err || RD_VALID !== m_rdv || RD_DATA !== m_rd) begin
          n_bad++;
          $display("FAIL random[%0d.%0d]: got cnt=%0d busy=%b done=%b ovf=%b cfg=%b vld=%b data=%h want %0d/%b/%b/%b/%b/%b/%h",
                   sess, c, COUNT, BUSY, CAP_DONE, ERR_OVF, ERR_CFG, RD_VALID, RD_DATA,
                   m_count, m_busy, m_done, m_ovf, m_err, m_rdv, m_rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_cfg_err();
    test_rst_mid();
    test_collide();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
